// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store alignment unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, LAST} lsu_state_t;

  typedef logic [3:0] be_t;

  // Byte-enable pattern for an access starting at lane 0.
  function automatic be_t base_be(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   base_be = 4'b0001;
      2'b01:   base_be = 4'b0011;
      default: base_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align_load_extract.sv
// Merges one or two read words into the addressed bytes and applies load extension.
module load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word1,
  input  logic [31:0] word0,
  input  logic [1:0]  k,
  input  logic        split,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [63:0] pair;
  logic [31:0] merged;

  always_comb begin
    pair   = split ? {word1, word0} : {32'h0, word1};
    merged = 32'(pair >> {k, 3'b000});
    case (funct3)
      F3_B:    rdata = {{24{merged[7]}}, merged[7:0]};
      F3_BU:   rdata = {24'h0, merged[7:0]};
      F3_H:    rdata = {{16{merged[15]}}, merged[15:0]};
      F3_HU:   rdata = {16'h0, merged[15:0]};
      default: rdata = merged;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: byte-lane steering, misaligned split into two
// memory cycles, load merge/extension and one completion pulse per request.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DM_ADDRESS-1:0]   req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [2:0]              req_funct3,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [DM_ADDRESS-3:0]   mem_waddr,
  output be_t                     mem_be,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);

  lsu_state_t state, state_nx;

  logic                  r_we, r_err;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_f3;
  logic [31:0]           word0;

  logic                  illegal_in, split;
  logic [1:0]            k;
  logic [2:0]            size;
  logic [DM_ADDRESS-3:0] waddr1, waddr2;
  logic [31:0]           rep, rot;
  logic [5:0]            sh;
  logic [31:0]           ext;

  assign req_ready = (state == IDLE) && rst_n;

  always_comb begin
    if (req_we)
      illegal_in = !(req_funct3 inside {F3_B, F3_H, F3_W});
    else
      illegal_in = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  end

  assign k      = r_addr[1:0];
  assign size   = (r_f3[1:0] == 2'b00) ? 3'd1 : (r_f3[1:0] == 2'b01) ? 3'd2 : 3'd4;
  assign split  = ({1'b0, k} + size) > 3'd4;
  assign waddr1 = r_addr[DM_ADDRESS-1:2];
  // Natural wrap: the top word is followed by word 0.
  assign waddr2 = waddr1 + {{(DM_ADDRESS-3){1'b0}}, 1'b1};
  assign sh     = {1'b0, k, 3'b000};

  always_comb begin
    case (r_f3[1:0])
      2'b00:   rep = {4{r_wdata[7:0]}};
      2'b01:   rep = {2{r_wdata[15:0]}};
      default: rep = r_wdata;
    endcase
    rot = (rep << sh) | (rep >> (6'd32 - sh));
  end

  load_extract u_extract (
    .word1  (mem_rdata),
    .word0  (word0),
    .k      (k),
    .split  (split),
    .funct3 (r_f3),
    .rdata  (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_f3    <= '0;
      word0   <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        r_we    <= req_we;
        r_err   <= illegal_in;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_f3    <= req_funct3;
      end
      if (state == ACC2 && !r_we) word0 <= mem_rdata;
    end
  end

  always_comb begin
    state_nx   = state;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state)
      IDLE: begin
        if (req_valid) state_nx = illegal_in ? LAST : ACC1;
      end
      ACC1: begin
        mem_waddr = waddr1;
        if (r_we) begin
          mem_we     = 1'b1;
          mem_be     = base_be(r_f3) << k;
          mem_wdata  = rot;
          resp_valid = !split;
        end else begin
          mem_re = 1'b1;
        end
        state_nx = split ? ACC2 : (r_we ? IDLE : LAST);
      end
      ACC2: begin
        mem_waddr = waddr2;
        if (r_we) begin
          mem_we     = 1'b1;
          mem_be     = base_be(r_f3) >> (3'd4 - {1'b0, k});
          mem_wdata  = rot;
          resp_valid = 1'b1;
          state_nx   = IDLE;
        end else begin
          mem_re   = 1'b1;
          state_nx = LAST;
        end
      end
      LAST: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = r_err ? 32'h0 : ext;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
